// File: rtl/imem_responder.sv
// Instruction-memory fetch responder: one-entry stage-1 register feeding a
// two-entry response FIFO, with range/alignment checking and a backdoor load port.
module imem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0013,
   localparam int         AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_req_valid,
   output logic          o_req_ready,
   input  logic [31:0]   i_req_addr,
   output logic          o_rsp_valid,
   input  logic          i_rsp_ready,
   output logic [31:0]   o_rsp_data,
   output logic [1:0]    o_rsp_err,
   input  logic          i_load_en,
   input  logic [AW-1:0] i_load_addr,
   input  logic [31:0]   i_load_data,
   output logic          o_fault
);

   localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH_WORDS - 1));

   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          r_s1_valid;
   logic [31:0]   r_s1_data;
   logic [1:0]    r_s1_err;

   logic [31:0]   r_fifo_data [2];
   logic [1:0]    r_fifo_err  [2];
   logic          r_wr_ptr;
   logic          r_rd_ptr;
   logic [1:0]    r_fifo_cnt;
   logic          r_fault;

   logic [31:0]   w_offset;
   logic [AW-1:0] w_idx;
   logic [1:0]    w_err;
   logic [1:0]    w_count;
   logic          w_pop;
   logic          w_accept;

   assign w_offset    = i_req_addr - BASE_ADDR;
   assign w_idx       = AW'(w_offset >> 2);
   assign w_err[0]    = (i_req_addr[1:0] != 2'b00);
   assign w_err[1]    = (i_req_addr < BASE_ADDR) || (i_req_addr > LAST_ADDR);

   assign w_count     = {1'b0, r_s1_valid} + r_fifo_cnt;
   assign w_pop       = o_rsp_valid && i_rsp_ready;
   assign o_req_ready = (w_count < 2'd2) || w_pop;
   assign w_accept    = i_req_valid && o_req_ready;

   assign o_rsp_valid = (r_fifo_cnt != 2'd0);
   assign o_rsp_data  = r_fifo_data[r_rd_ptr];
   assign o_rsp_err   = r_fifo_err[r_rd_ptr];
   assign o_fault     = r_fault;

   // Program-load port; memory contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (i_load_en) begin
         r_mem[i_load_addr] <= i_load_data;
      end
   end

   // Memory is read on the accepting edge, so a same-edge load is not yet visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= 32'h0000_0000;
         r_s1_err   <= 2'b00;
      end else if (w_accept) begin
         r_s1_valid <= 1'b1;
         r_s1_err   <= w_err;
         r_s1_data  <= (w_err != 2'b00) ? NOP_WORD : r_mem[w_idx];
      end else begin
         r_s1_valid <= 1'b0;
      end
   end

   // Stage 1 always drains into the FIFO; the count limit guarantees room.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_fifo_data[i] <= 32'h0000_0000;
            r_fifo_err[i]  <= 2'b00;
         end
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_fifo_cnt <= 2'd0;
      end else begin
         if (r_s1_valid) begin
            r_fifo_data[r_wr_ptr] <= r_s1_data;
            r_fifo_err[r_wr_ptr]  <= r_s1_err;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_fifo_cnt <= r_fifo_cnt + {1'b0, r_s1_valid} - {1'b0, w_pop};
      end
   end

   // Sticky fault flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fault <= 1'b0;
      end else if (w_accept && (w_err != 2'b00)) begin
         r_fault <= 1'b1;
      end else begin
         r_fault <= r_fault;
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder; inputs change and outputs
// are sampled on the falling clock edge.
module tb_imem_responder;

   logic        clk;
   logic        rst_n;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [31:0] i_req_addr;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_data;
   logic [1:0]  o_rsp_err;
   logic        i_load_en;
   logic [9:0]  i_load_addr;
   logic [31:0] i_load_data;
   logic        o_fault;

   int n_cmp = 0;
   int n_err = 0;

   imem_responder dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_addr  (i_req_addr),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_data  (o_rsp_data),
      .o_rsp_err   (o_rsp_err),
      .i_load_en   (i_load_en),
      .i_load_addr (i_load_addr),
      .i_load_data (i_load_data),
      .o_fault     (o_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [9:0] a, input logic [31:0] d);
      i_load_en = 1'b1; i_load_addr = a; i_load_data = d;
      @(negedge clk);
      i_load_en = 1'b0;
   endtask

   // Single isolated fetch with rsp_ready held high.
   task automatic fetch(input string tag, input logic [31:0] addr,
                        input logic [31:0] ed, input logic [1:0] ee);
      i_rsp_ready = 1'b1;
      i_req_valid = 1'b1; i_req_addr = addr;
      chk({tag, "_ready"}, 32'(o_req_ready), 32'd1);
      @(negedge clk);
      i_req_valid = 1'b0; i_load_en = 1'b0;
      chk({tag, "_t1_valid"}, 32'(o_rsp_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(o_rsp_valid), 32'd1);
      chk({tag, "_data"}, o_rsp_data, ed);
      chk({tag, "_err"}, 32'(o_rsp_err), 32'(ee));
      @(negedge clk);
      chk({tag, "_drained"}, 32'(o_rsp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; i_req_valid = 1'b0; i_req_addr = 32'h0; i_rsp_ready = 1'b0;
      i_load_en = 1'b0; i_load_addr = 10'h0; i_load_data = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(o_rsp_valid), 32'd0);
      chk("rst_data",  o_rsp_data, 32'h0);
      chk("rst_err",   32'(o_rsp_err), 32'd0);
      chk("rst_fault", 32'(o_fault), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(o_req_ready), 32'd1);

      for (int i = 0; i < 4; i++) load(10'(i), 32'hA0 + 32'(i));
      load(10'd5, 32'h0000_0055);
      load(10'd1023, 32'h5555_AAAA);

      // Streaming: four back-to-back fetches, response two cycles after accept.
      i_rsp_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("stream%0d_ready", k), 32'(o_req_ready), 32'd1);
         chk($sformatf("stream%0d_valid", k), 32'(o_rsp_valid), (k >= 2 && k <= 5) ? 32'd1 : 32'd0);
         if (k >= 2 && k <= 5) begin
            chk($sformatf("stream%0d_data", k), o_rsp_data, 32'hA0 + 32'(k - 2));
            chk($sformatf("stream%0d_err", k), 32'(o_rsp_err), 32'd0);
         end
         i_req_valid = (k < 4);
         i_req_addr  = 32'h0100_0000 + 32'(4 * k);
         @(negedge clk);
      end
      i_req_valid = 1'b0;

      // Backpressure: third request stalls until the first pop.
      i_rsp_ready = 1'b0;
      i_req_valid = 1'b1; i_req_addr = 32'h0100_0000;
      chk("bp_ready0", 32'(o_req_ready), 32'd1);
      @(negedge clk);
      i_req_addr = 32'h0100_0004;
      chk("bp_ready1", 32'(o_req_ready), 32'd1);
      @(negedge clk);
      i_req_addr = 32'h0100_0008;
      chk("bp_ready2", 32'(o_req_ready), 32'd0);
      chk("bp_head0", o_rsp_data, 32'hA0);
      @(negedge clk);
      i_req_addr = 32'h0100_000C;
      chk("bp_ready_stall", 32'(o_req_ready), 32'd0);
      chk("bp_head_stable", o_rsp_data, 32'hA0);
      i_req_addr = 32'h0100_0008;
      i_rsp_ready = 1'b1;
      #1;
      chk("bp_ready_on_pop", 32'(o_req_ready), 32'd1);
      @(negedge clk);
      i_req_valid = 1'b0;
      chk("bp_order1", o_rsp_data, 32'hA1);
      @(negedge clk);
      chk("bp_order2_valid", 32'(o_rsp_valid), 32'd1);
      chk("bp_order2", o_rsp_data, 32'hA2);
      @(negedge clk);
      chk("bp_empty", 32'(o_rsp_valid), 32'd0);

      // Error classification.
      chk("fault_pre", 32'(o_fault), 32'd0);
      fetch("misalign", 32'h0100_0002, 32'h0000_0013, 2'b01);
      chk("fault_set", 32'(o_fault), 32'd1);
      fetch("oor_hi",   32'h0100_1000, 32'h0000_0013, 2'b10);
      fetch("oor_lo",   32'h00FF_FFFC, 32'h0000_0013, 2'b10);
      fetch("last",     32'h0100_0FFC, 32'h5555_AAAA, 2'b00);
      fetch("both",     32'h0100_1001, 32'h0000_0013, 2'b11);
      chk("fault_sticky", 32'(o_fault), 32'd1);

      // Reset with two responses outstanding.
      i_rsp_ready = 1'b0;
      i_req_valid = 1'b1; i_req_addr = 32'h0100_0000;
      @(negedge clk);
      i_req_addr = 32'h0100_0004;
      @(negedge clk);
      i_req_valid = 1'b0;
      chk("mid_valid", 32'(o_rsp_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(o_rsp_valid), 32'd0);
      chk("mid_rst_fault", 32'(o_fault), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      i_rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("post_rst%0d_valid", k), 32'(o_rsp_valid), 32'd0);
         chk($sformatf("post_rst%0d_ready", k), 32'(o_req_ready), 32'd1);
         @(negedge clk);
      end
      fetch("mem_kept", 32'h0100_0004, 32'hA1, 2'b00);

      // Load and fetch of the same word in one cycle: old word first.
      i_load_en = 1'b1; i_load_addr = 10'd5; i_load_data = 32'hDEAD_BEEF;
      fetch("ld_same", 32'h0100_0014, 32'h0000_0055, 2'b00);
      fetch("ld_after", 32'h0100_0014, 32'hDEAD_BEEF, 2'b00);
      chk("fault_clean", 32'(o_fault), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
